hash_byte_feeder: RTL and testbench
===================================

Name: hash_byte_feeder

Overview:
Upstream stage of full_hash: accepts 32-bit message words from the host/DMA side and serializes them into the byte stream full_hash consumes (Byte, F_dr, End_Of_File, start). Buffers words in a small FIFO, frames each message with a start pulse, and marks the last valid byte with End_Of_File. Waits for the digest (H_ready) before opening the next message.

Parameters:
DEPTH, 4, FIFO depth in words; power of two, >= 2
MSB_FIRST, 1, 1 = bits [31:24] sent first; 0 = bits [7:0] sent first

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  synchronous, active-high reset (1 = reset), sampled on clk
in_data  input  32  message word
in_valid  input  1  in_data/in_last/in_nbytes valid
in_last  input  1  word is last of the message
in_nbytes  input  2  valid bytes in last word; 0 = 4, 1..3 = count; ignored when in_last = 0
in_ready  output  1  feeder accepts word this cycle
H_ready  input  1  full_hash digest-ready flag
F_rtr  input  1  full_hash ready to receive a byte
start  output  1  one-cycle message start pulse to full_hash
Byte  output  8  byte to full_hash
F_dr  output  1  Byte valid
End_Of_File  output  1  Byte is the last byte of the message
busy  output  1  message in flight (state != IDLE)

Behaviour:
- Reset (rst_n = 1 at a rising edge): FIFO flushed, FSM -> IDLE, byte index 0. start, F_dr, End_Of_File, busy = 0, Byte = 8'h00. in_ready = 0 while rst_n = 1, then = !full. Reset mid-message abandons it; no EOF issued.
- FIFO entry = {last, nbytes, data}. Push on in_valid && in_ready. in_ready = !full; no pass-through when full, even with a same-cycle pop. Push and pop in the same cycle when not full: count unchanged.
- Transfer rule: one byte moves when F_dr && F_rtr in the same cycle. While F_dr = 1 and F_rtr = 0, Byte and End_Of_File are held stable; F_dr never drops without a transfer.
- FSM states: IDLE, START, LOAD, STREAM, WAIT_DIG.
- IDLE: if FIFO non-empty and H_ready = 1 -> START.
- START: start = 1 for exactly this cycle -> LOAD.
- LOAD: pop head into a 32-bit shift register. Byte count = 4, or nbytes (0 -> 4) when last = 1. Byte index = 0 -> STREAM.
- STREAM: F_dr = 1 and Byte = current byte in MSB_FIRST order. End_Of_File = 1 only on the final byte of a last = 1 word. On a transfer:
  - Not the final byte of the word: advance index.
  - Final byte, last = 0, FIFO non-empty: pop the next word the same cycle, zero bubble.
  - Final byte, last = 0, FIFO empty: -> LOAD; F_dr = 0 until a word arrives (LOAD waits while empty).
  - Final byte, last = 1: -> WAIT_DIG.
- WAIT_DIG: F_dr = 0. Wait for H_ready = 0 sampled, then H_ready = 1 sampled (rising edge) -> IDLE. Words of the next message may queue in the FIFO meanwhile but are not popped.
- Latency: word pushed into an empty FIFO at edge N, FSM in IDLE, H_ready = 1: start high in cycle N+1, LOAD in N+2, first F_dr in N+3.
- A last word with nbytes = 1 gives a single byte with End_Of_File = 1. Unused bytes of that word are never presented.
- All outputs are registered or decoded from the state register only; no input-to-output combinational path except in_ready (from full).

Optional Feature:
HASH_FEEDER_LEN_EN: when defined, adds output msg_len [31:0], the byte count of the current/last message. Cleared to 0 in START, +1 on every transfer, held after EOF until the next START; reset value 0. When undefined the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset: drive rst_n = 1 for 3 cycles with in_valid = 1 -> in_ready = 0, F_dr = 0, start = 0, Byte = 0; FIFO empty after release.
- One word 32'hA1B2C3D4, last = 1, nbytes = 0, MSB_FIRST = 1, F_rtr = 1 -> start at N+1; bytes A1, B2, C3, D4 on N+3..N+6; End_Of_File only with D4.
- Two words 32'h11223344 (last = 0), then 32'h55667788 (last = 1, nbytes = 2), F_rtr = 1 -> bytes 11 22 33 44 55 66 with no gap; EOF with 66; 77 and 88 never driven.
- Backpressure: F_rtr toggling 1,0,0,1 during a message -> Byte/End_Of_File stable while F_rtr = 0; no byte lost or duplicated.
- FIFO full: push DEPTH+2 words while H_ready = 0 -> in_ready = 0 after DEPTH pushes. Second message queued during WAIT_DIG starts only after an H_ready 0->1 edge.
- With HASH_FEEDER_LEN_EN: 3-byte message (one last word, nbytes = 3) -> msg_len = 3 after EOF, reset to 0 at the next start.

Source files
------------

// File: rtl/hash_byte_feeder_if.sv
// hash_byte_feeder_if: word-in / byte-out signal bundle between the host side,
// the feeder and full_hash. The slave modport is the feeder's view; the master
// modport is the view of whatever drives words in and consumes bytes out.
// Optional macro HASH_FEEDER_LEN_EN adds the msg_len signal.
interface hash_byte_feeder_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic [1:0]  in_nbytes;
  logic        in_ready;
  logic        H_ready;
  logic        F_rtr;
  logic        start;
  logic [7:0]  Byte;
  logic        F_dr;
  logic        End_Of_File;
  logic        busy;
`ifdef HASH_FEEDER_LEN_EN
  logic [31:0] msg_len;
`endif

  modport slave (
    input  in_data, in_valid, in_last, in_nbytes, H_ready, F_rtr,
    output in_ready, start, Byte, F_dr, End_Of_File, busy
`ifdef HASH_FEEDER_LEN_EN
    , output msg_len
`endif
  );

  modport master (
    output in_data, in_valid, in_last, in_nbytes, H_ready, F_rtr,
    input  in_ready, start, Byte, F_dr, End_Of_File, busy
`ifdef HASH_FEEDER_LEN_EN
    , input msg_len
`endif
  );
endinterface

// File: rtl/hash_byte_feeder.sv
// hash_byte_feeder: buffers 32-bit message words in a small FIFO and streams
// them byte by byte into full_hash, framing each message with a start pulse
// and flagging its last valid byte with End_Of_File. The next message is not
// opened until full_hash has produced its digest (H_ready falls, then rises).
// rst_n is a synchronous, active-high reset despite its name.
// Optional macro HASH_FEEDER_LEN_EN adds msg_len, the byte count of the
// current/last message.
module hash_byte_feeder #(
  parameter int DEPTH     = 4,     // FIFO depth in words, power of two, >= 2
  parameter bit MSB_FIRST = 1'b1   // 1: bits [31:24] go out first
) (
  input  logic              clk,
  input  logic              rst_n,
  hash_byte_feeder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        last;
    logic [1:0]  nbytes;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_STREAM,
    S_WAIT_DIG
  } state_t;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  entry_t      mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        full, empty, push, pop;
  entry_t      head;

  // Streaming state
  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  fin_q, fin_d;       // index of the final byte of this word
  logic        last_q, last_d;
  logic        seen_low_q, seen_low_d;
  logic        xfer, final_byte;
  logic [7:0]  cur_byte;
  logic [31:0] word_shifted;

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  // No pass-through when full: acceptance depends only on the stored count.
  assign bus.in_ready = !rst_n && !full;
  assign push         = bus.in_valid && bus.in_ready;

  assign xfer       = (state_q == S_STREAM) && bus.F_rtr;
  assign final_byte = (idx_q == fin_q);

  assign cur_byte     = MSB_FIRST ? word_q[31:24] : word_q[7:0];
  assign word_shifted = MSB_FIRST ? {word_q[23:0], 8'h00} : {8'h00, word_q[31:8]};

  // FIFO pointer update; reset flushes the queue
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values regardless of statement order.
    if (rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, so resetting the data would only cost flops.
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {bus.in_last, bus.in_nbytes, bus.in_data};
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      idx_q      <= '0;
      fin_q      <= '0;
      last_q     <= 1'b0;
      seen_low_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      fin_q      <= fin_d;
      last_q     <= last_d;
      seen_low_q <= seen_low_d;
    end
  end

  // Next-state and pop decode
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    word_d     = word_q;
    idx_d      = idx_q;
    fin_d      = fin_q;
    last_d     = last_q;
    seen_low_d = seen_low_q;
    pop        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!empty && bus.H_ready) state_d = S_START;
      end
      S_START: begin
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (bus.F_rtr) begin
          if (!final_byte) begin
            idx_d  = idx_q + 2'd1;
            word_d = word_shifted;
          end else if (!last_q) begin
            // Chain straight into the next word when one is queued.
            if (!empty) pop = 1'b1;
            else        state_d = S_LOAD;
          end else begin
            state_d    = S_WAIT_DIG;
            seen_low_d = 1'b0;
          end
        end
      end
      S_WAIT_DIG: begin
        // Only a fresh digest counts: H_ready must be seen low, then high.
        if (!bus.H_ready)    seen_low_d = 1'b1;
        else if (seen_low_q) state_d    = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (pop) begin
      word_d = head.data;
      last_d = head.last;
      idx_d  = 2'd0;
      // nbytes = 0 means four bytes; nbytes - 1 wraps 0 to index 3.
      fin_d  = head.last ? (head.nbytes - 2'd1) : 2'd3;
    end
  end

  // Outputs decoded from registered state only
  assign bus.start       = (state_q == S_START);
  assign bus.F_dr        = (state_q == S_STREAM);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.Byte        = (state_q == S_STREAM) ? cur_byte : 8'h00;
  assign bus.End_Of_File = (state_q == S_STREAM) && last_q && final_byte;

`ifdef HASH_FEEDER_LEN_EN
  logic [31:0] msg_len_q;

  // Message byte counter: cleared when a message opens, held after EOF
  always_ff @(posedge clk) begin
    if (rst_n)                   msg_len_q <= '0;
    else if (state_q == S_START) msg_len_q <= '0;
    else if (xfer)               msg_len_q <= msg_len_q + 32'd1;
  end

  assign bus.msg_len = msg_len_q;
`else
  logic unused_xfer;
  assign unused_xfer = xfer;
`endif

endmodule

// File: tb/tb_hash_byte_feeder.sv
// tb_hash_byte_feeder: self-checking bench for hash_byte_feeder. Every byte
// that crosses the F_dr/F_rtr handshake is compared with a byte queue built
// from the pushed words; directed tables and sequences cover reset, latency,
// chaining, backpressure, FIFO full and digest gating.
// Define HASH_FEEDER_LEN_EN to also check msg_len.
module tb_hash_byte_feeder;
  localparam int DEPTH     = 4;
  localparam bit MSB_FIRST = 1'b1;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  hash_byte_feeder_if bus ();

  hash_byte_feeder #(.DEPTH(DEPTH), .MSB_FIRST(MSB_FIRST)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: the byte stream the spec says each pushed word yields
  typedef struct {
    logic [7:0] b;
    logic       eof;
  } exp_t;
  exp_t exp_q[$];

  function automatic void model_push(input logic [31:0] d, input bit l, input logic [1:0] nb);
    int   n;
    int   sh;
    exp_t e;
    n = (l && nb != 2'd0) ? int'(nb) : 4;
    for (int k = 0; k < n; k++) begin
      sh    = MSB_FIRST ? 8 * (3 - k) : 8 * k;
      e.b   = 8'(d >> sh);
      e.eof = l && (k == n - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Monitor bookkeeping
  int         cyc = 0, msg_cnt = 0, eof_cnt = 0, start_cnt = 0;
  int         last_msg_bytes = 0, first_cyc = 0, eof_cyc = 0;
  logic [7:0] eof_byte = 8'h00;
  logic       prev_dr = 1'b0, prev_rtr = 1'b0, prev_rst = 1'b1, prev_eof = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  exp_t       mon_e;

  // Byte monitor: compares transfers to the model and checks hold-under-stall
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n && !prev_rst && prev_dr && !prev_rtr) begin
        check("hold_fdr", bus.F_dr, 1);
        check("hold_byte", bus.Byte, prev_byte);
        check("hold_eof", bus.End_Of_File, prev_eof);
      end
      if (!rst_n && bus.F_dr && bus.F_rtr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got 0x%0h, expected no byte", bus.Byte);
        end else begin
          mon_e = exp_q.pop_front();
          check("byte_value", bus.Byte, mon_e.b);
          check("byte_eof", bus.End_Of_File, mon_e.eof);
        end
        msg_cnt++;
        if (msg_cnt == 1) first_cyc = cyc;
        if (bus.End_Of_File) begin
          eof_cnt++;
          last_msg_bytes = msg_cnt;
          eof_cyc        = cyc;
          eof_byte       = bus.Byte;
          msg_cnt        = 0;
        end
      end
      if (!rst_n && bus.start) start_cnt++;
      prev_dr   = bus.F_dr;
      prev_rtr  = bus.F_rtr;
      prev_rst  = rst_n;
      prev_byte = bus.Byte;
      prev_eof  = bus.End_Of_File;
    end
  end

  // Random full_hash readiness when enabled
  bit rand_rtr = 1'b0;
  initial begin : rtr_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_rtr) bus.F_rtr = ($urandom_range(0, 3) != 0);
    end
  end

  // Offer one word for up to budget cycles; ok reports acceptance
  task automatic push(input logic [31:0] d, input bit l, input logic [1:0] nb,
                      input int budget, output bit ok);
    bit r;
    @(posedge clk);
    #1;
    bus.in_data   = d;
    bus.in_last   = l;
    bus.in_nbytes = nb;
    bus.in_valid  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        ok = 1'b1;
        model_push(d, l, nb);
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_eof(input int target);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk);
      #2;
      seen = (eof_cnt >= target);
    end
    check("eof_seen", seen, 1);
  endtask

  // full_hash digest: H_ready low for two edges, then high; FSM must go idle
  task automatic digest();
    bit seen = 1'b0;
    @(posedge clk);
    #1 bus.H_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.H_ready = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = !bus.busy;
    end
    check("back_to_idle", seen, 1);
  endtask

  typedef struct {
    logic [31:0] data;
    logic [1:0]  nbytes;
    int          exp_len;
    logic [7:0]  exp_eof_byte;
  } vec_t;
  vec_t vecs[5];

  bit ok;
  int target, sc, nw, exp_len;
  logic [1:0] nb;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    vecs[0] = '{32'hA1B2C3D4, 2'd0, 4, 8'hD4};
    vecs[1] = '{32'hA1B2C3D4, 2'd1, 1, 8'hA1};
    vecs[2] = '{32'hA1B2C3D4, 2'd2, 2, 8'hB2};
    vecs[3] = '{32'h0BADF00D, 2'd3, 3, 8'hF0};
    vecs[4] = '{32'hDEADBEEF, 2'd0, 4, 8'hEF};

    bus.in_data   = 32'h12345678;
    bus.in_last   = 1'b1;
    bus.in_nbytes = 2'd0;
    bus.in_valid  = 1'b1;
    bus.H_ready   = 1'b1;
    bus.F_rtr     = 1'b1;

    // Reset with a word offered: nothing accepted, outputs quiet
    repeat (3) begin
      @(negedge clk);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_f_dr", bus.F_dr, 0);
      check("rst_start", bus.start, 0);
      check("rst_byte", bus.Byte, 8'h00);
      check("rst_busy", bus.busy, 0);
    end
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("fifo_empty_after_reset", bus.busy, 0);
    check("in_ready_after_reset", bus.in_ready, 1);

    // Latency of a single word into an idle feeder
    push(32'hA1B2C3D4, 1'b1, 2'd0, 10, ok);
    check("lat_push_ok", ok, 1);
    @(negedge clk) check("lat_n_start", bus.start, 0);
    @(negedge clk) check("lat_n1_start", bus.start, 1);
    @(negedge clk);
    check("lat_n2_start", bus.start, 0);
    check("lat_n2_fdr", bus.F_dr, 0);
    @(negedge clk);
    check("lat_n3_fdr", bus.F_dr, 1);
    check("lat_n3_byte", bus.Byte, 8'hA1);
    wait_eof(1);
    check("lat_msg_bytes", last_msg_bytes, 4);
    check("lat_eof_byte", eof_byte, 8'hD4);
    check("lat_no_gap", eof_cyc - first_cyc, 3);
    digest();

    // Two words chained with no bubble, partial last word
    push(32'h11223344, 1'b0, 2'd0, 10, ok);
    push(32'h55667788, 1'b1, 2'd2, 10, ok);
    wait_eof(2);
    check("chain_msg_bytes", last_msg_bytes, 6);
    check("chain_eof_byte", eof_byte, 8'h66);
    check("chain_no_gap", eof_cyc - first_cyc, 5);
    digest();
    check("chain_drained", exp_q.size(), 0);

    // Single-word message table
    for (int i = 0; i < 5; i++) begin
      target = eof_cnt + 1;
      push(vecs[i].data, 1'b1, vecs[i].nbytes, 10, ok);
`ifdef HASH_FEEDER_LEN_EN
      @(negedge clk) check("len_held", bus.msg_len, 32'(last_msg_bytes));
      @(negedge clk);
      @(negedge clk) check("len_cleared", bus.msg_len, 0);
`endif
      wait_eof(target);
      check("tbl_msg_bytes", last_msg_bytes, vecs[i].exp_len);
      check("tbl_eof_byte", eof_byte, vecs[i].exp_eof_byte);
`ifdef HASH_FEEDER_LEN_EN
      check("tbl_msg_len", bus.msg_len, 32'(vecs[i].exp_len));
`endif
      digest();
    end

    // Backpressure pattern 1,0,0,1 while streaming
    @(posedge clk);
    #1 bus.F_rtr = 1'b0;
    target = eof_cnt + 1;
    push(32'hCAFEF00D, 1'b1, 2'd0, 10, ok);
    for (int i = 0; i < 20 && !bus.F_dr; i++) @(negedge clk);
    foreach (vecs[i]) if (i < 4) begin
      @(posedge clk);
      #1 bus.F_rtr = (i == 0 || i == 3);
    end
    @(posedge clk);
    #1 bus.F_rtr = 1'b1;
    wait_eof(target);
    check("bp_msg_bytes", last_msg_bytes, 4);
    check("bp_eof_byte", eof_byte, 8'h0D);
    digest();

    // Reset mid-message abandons it without an EOF
    target = eof_cnt;
    push(32'h01020304, 1'b1, 2'd0, 10, ok);
    for (int i = 0; i < 20 && msg_cnt < 2; i++) @(negedge clk);
    @(posedge clk);
    #1;
    bus.F_rtr = 1'b0;
    rst_n     = 1'b1;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    exp_q.delete();
    msg_cnt   = 0;
    bus.F_rtr = 1'b1;
    repeat (3) @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_fdr", bus.F_dr, 0);
    check("midrst_no_eof", eof_cnt, target);

    // FIFO full while the digest is outstanding, then digest gating
    @(posedge clk);
    #1 bus.H_ready = 1'b0;
    push(32'hAABBCCDD, 1'b1, 2'd0, 10, ok);  // message A
    check("full_push0", ok, 1);
    push(32'h10203040, 1'b0, 2'd0, 10, ok);  // message B
    check("full_push1", ok, 1);
    push(32'h50607080, 1'b0, 2'd0, 10, ok);
    check("full_push2", ok, 1);
    push(32'h90A0B0C0, 1'b1, 2'd1, 10, ok);
    check("full_push3", ok, 1);
    for (int i = 0; i < 2; i++) begin
      push(32'hFFFF0000, 1'b1, 2'd0, 3, ok);
      check("full_rejected", ok, 0);
    end
    @(negedge clk) check("full_in_ready", bus.in_ready, 0);
    check("full_not_started", bus.busy, 0);
    target = eof_cnt + 1;
    @(posedge clk);
    #1 bus.H_ready = 1'b1;
    wait_eof(target);
    check("msgA_bytes", last_msg_bytes, 4);
    push(32'h77665544, 1'b1, 2'd3, 5, ok);  // message C queued during WAIT_DIG
    check("waitdig_push", ok, 1);
    sc = start_cnt;
    repeat (8) @(negedge clk);
    check("waitdig_no_start", start_cnt, sc);
    check("waitdig_busy", bus.busy, 1);
    check("waitdig_no_byte", msg_cnt, 0);
    digest();
    wait_eof(target + 1);
    check("msgB_bytes", last_msg_bytes, 9);
    check("msgB_eof_byte", eof_byte, 8'h90);
    check("msgB_one_start", start_cnt, sc + 1);
    digest();
    wait_eof(target + 2);
    check("msgC_bytes", last_msg_bytes, 3);
    check("msgC_eof_byte", eof_byte, 8'h55);
    digest();

    // Randomized messages with random F_rtr
    rand_rtr = 1'b1;
    for (int m = 0; m < 8; m++) begin
      nw     = $urandom_range(1, 3);
      nb     = 2'd0;
      target = eof_cnt + 1;
      for (int w = 0; w < nw; w++) begin
        nb = 2'($urandom_range(0, 3));
        push($urandom, (w == nw - 1), nb, 20, ok);
        check("rnd_push", ok, 1);
      end
      exp_len = 4 * (nw - 1) + ((nb == 2'd0) ? 4 : int'(nb));
      wait_eof(target);
      check("rnd_msg_bytes", last_msg_bytes, exp_len);
      digest();
    end
    rand_rtr = 1'b0;
    @(posedge clk);
    #1 bus.F_rtr = 1'b1;
    repeat (4) @(negedge clk);
    check("final_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
